// File: rtl/ram_access_arbiter.sv
// Arbitrates the single-port main RAM between the Z80 bus and the download write stream.
// Optional ARB_STATS_EN enables the dl_count download byte counter.
module ram_access_arbiter #(
  parameter int AW            = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_ena,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [24:0]   dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          cpu_mreq,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_dout,
  output logic [7:0]    cpu_din,
  output logic          cpu_wait_n,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  input  logic [7:0]    ram_dout,
  output logic          dl_busy,
  output logic          dl_overflow,
  output logic          dl_range_err,
  output logic [15:0]   dl_count
);

  typedef enum logic [1:0] {IDLE, HOLD, DRAIN, SETTLE} state_t;

  localparam int IW = $clog2(FIFO_DEPTH);
  localparam int PW = IW + 1;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES);

  state_t        state, state_next;
  logic [CW-1:0] settle_cnt, cnt_next;
  logic          wait_n_next, we_next;
  logic [AW-1:0] addr_next;
  logic [7:0]    din_next;

  logic [AW+7:0] fifo_mem [FIFO_DEPTH];
  logic [AW+7:0] rd_entry;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, in_range, push, pop;
  logic          ovf_evt, rng_evt, dl_active_q, dl_rise;

  assign cpu_din    = ram_dout;
  assign dl_busy    = (state != IDLE);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign rd_entry   = fifo_mem[rd_ptr[IW-1:0]];

  // A full FIFO still accepts a write when an entry leaves in the same cycle.
  assign in_range = ((dl_addr >> AW) == 25'd0);
  assign push     = dl_wr && in_range && (!fifo_full || pop);
  assign ovf_evt  = dl_wr && in_range && fifo_full && !pop;
  assign rng_evt  = dl_wr && !in_range;
  assign dl_rise  = dl_active && !dl_active_q;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[IW-1:0]] <= {dl_addr[AW-1:0], dl_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A new error event wins over the clear caused by a download start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_active_q  <= 1'b0;
      dl_overflow  <= 1'b0;
      dl_range_err <= 1'b0;
    end else begin
      dl_active_q <= dl_active;
      if (ovf_evt)      dl_overflow <= 1'b1;
      else if (dl_rise) dl_overflow <= 1'b0;
      if (rng_evt)      dl_range_err <= 1'b1;
      else if (dl_rise) dl_range_err <= 1'b0;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        dl_count <= '0;
    else if (dl_rise) dl_count <= '0;
    else if (pop)     dl_count <= dl_count + 16'd1;
  end
`else
  assign dl_count = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      cpu_wait_n <= 1'b1;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= cnt_next;
      cpu_wait_n <= wait_n_next;
      ram_addr   <= addr_next;
      ram_din    <= din_next;
      ram_we     <= we_next;
    end
  end

  // In IDLE the CPU request is still registered on the cycle a download starts.
  always_comb begin
    state_next  = state;
    cnt_next    = settle_cnt;
    wait_n_next = cpu_wait_n;
    addr_next   = ram_addr;
    din_next    = ram_din;
    we_next     = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        addr_next = cpu_addr;
        din_next  = cpu_dout;
        we_next   = clk_ena && cpu_mreq && cpu_wr;
        if (dl_active || !fifo_empty) begin
          state_next  = HOLD;
          wait_n_next = 1'b0;
        end
      end
      HOLD: begin
        if (clk_ena) state_next = DRAIN;
      end
      DRAIN: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          addr_next = rd_entry[AW+7:8];
          din_next  = rd_entry[7:0];
          we_next   = 1'b1;
        end else if (!dl_active) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (dl_active || !fifo_empty) begin
          state_next = DRAIN;
        end else if (settle_cnt == CW'(1)) begin
          state_next  = IDLE;
          wait_n_next = 1'b1;
        end else begin
          cnt_next = settle_cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Self-checking bench for ram_access_arbiter: randomized download/CPU traffic checked
// against an ordered write scoreboard and the arbiter's timing rules.
module tb_ram_access_arbiter;

  localparam int AW            = 16;
  localparam int FIFO_DEPTH    = 4;
  localparam int SETTLE_CYCLES = 2;
`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk_ena = 1'b0, dl_active = 1'b0, dl_wr = 1'b0;
  logic [24:0]   dl_addr = '0;
  logic [7:0]    dl_data = '0;
  logic          cpu_mreq = 1'b0, cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_dout = '0, ram_dout = '0;
  logic [7:0]    cpu_din, ram_din;
  logic          cpu_wait_n, ram_we, dl_busy, dl_overflow, dl_range_err;
  logic [AW-1:0] ram_addr;
  logic [15:0]   dl_count;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_addr[$], seen_addr[$];
  logic [7:0]    exp_data[$], seen_data[$];
  logic [7:0]    mem_img [0:(1<<AW)-1];

  ram_access_arbiter #(.AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .clk(clk), .reset(reset), .clk_ena(clk_ena), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .cpu_mreq(cpu_mreq), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .dl_busy(dl_busy), .dl_overflow(dl_overflow), .dl_range_err(dl_range_err),
    .dl_count(dl_count)
  );

  always #5 clk = ~clk;

  // The RAM macro: every write strobe lands in the image and the observed write log.
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      seen_addr.push_back(ram_addr);
      seen_data.push_back(ram_din);
      mem_img[ram_addr] = ram_din;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    exp_addr.delete(); exp_data.delete();
    seen_addr.delete(); seen_data.delete();
  endtask

  // Counts edges from the dl_active drop until wait is released (bounded).
  task automatic wait_release(output int cyc);
    cyc = 0;
    while (cpu_wait_n !== 1'b1 && cyc < 50) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic start_download(input logic ena);
    dl_active = 1'b1;
    clk_ena   = ena;
    tick(3);
  endtask

  task automatic test_reset();
    tick(2);
    checks++;
    if ({cpu_wait_n, ram_we, ram_addr, ram_din, dl_busy, dl_overflow, dl_range_err, dl_count}
        !== {1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got wait_n=%b we=%b addr=%h din=%h busy=%b ovf=%b rng=%b cnt=%0d",
               cpu_wait_n, ram_we, ram_addr, ram_din, dl_busy, dl_overflow, dl_range_err, dl_count);
    end
    reset = 1'b0;
    tick(2);
    checks++;
    if (cpu_wait_n !== 1'b1 || dl_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got wait_n=%b busy=%b expected 1 0", cpu_wait_n, dl_busy);
    end
  endtask

  task automatic test_cpu_only();
    bit waited = 0;
    clear_logs();
    for (int k = 0; k < 7; k++) begin
      cpu_mreq = 1'b1;
      cpu_wr   = (k == 0) ? 1'b1 : 1'($urandom);
      cpu_addr = (k == 0) ? 16'h1234 : 16'($urandom);
      cpu_dout = (k == 0) ? 8'h5A : 8'($urandom);
      if (cpu_wr) begin
        exp_addr.push_back(cpu_addr);
        exp_data.push_back(cpu_dout);
      end
      for (int i = 0; i < 4; i++) begin
        clk_ena = (i == 0);
        tick(1);
        if (cpu_wait_n !== 1'b1) waited = 1;
      end
    end
    cpu_mreq = 1'b0; cpu_wr = 1'b0;
    tick(2);
    checks++;
    if (waited) begin
      errors++;
      $display("[TB] FAIL cpu_wait: got wait asserted expected wait_n=1 throughout");
    end
    checks++;
    if (seen_addr.size() != exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL cpu_write_count: got %0d expected %0d", seen_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if ({seen_addr[i], seen_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          errors++;
          $display("[TB] FAIL cpu_write[%0d]: got %h/%h expected %h/%h", i,
                   seen_addr[i], seen_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    ram_dout = 8'($urandom);
    #1;
    checks++;
    if (cpu_din !== ram_dout) begin
      errors++;
      $display("[TB] FAIL cpu_din: got %h expected %h", cpu_din, ram_dout);
    end
  endtask

  task automatic test_download8();
    bit released_early = 0;
    int cyc;
    clear_logs();
    // CPU write in the same cycle the download starts must still complete.
    cpu_mreq = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h4321; cpu_dout = 8'hC3;
    exp_addr.push_back(16'h4321); exp_data.push_back(8'hC3);
    dl_active = 1'b1; clk_ena = 1'b1;
    tick(1);
    cpu_mreq = 1'b0; cpu_wr = 1'b0;
    checks++;
    if (cpu_wait_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_assert: got wait_n=%b expected 0", cpu_wait_n);
    end
    tick(2);
    for (int i = 0; i < 8; i++) begin
      dl_wr = 1'b1; dl_addr = 25'h8000 + 25'(i); dl_data = 8'($urandom);
      exp_addr.push_back(dl_addr[AW-1:0]); exp_data.push_back(dl_data);
      tick(1);
      if (cpu_wait_n !== 1'b0) released_early = 1;
    end
    dl_wr = 1'b0;
    tick(4);
    if (cpu_wait_n !== 1'b0) released_early = 1;
    dl_active = 1'b0;
    wait_release(cyc);
    checks++;
    if (released_early) begin
      errors++;
      $display("[TB] FAIL dl8_wait_low: got wait_n=1 during download expected 0");
    end
    checks++;
    if (cyc != SETTLE_CYCLES + 1) begin
      errors++;
      $display("[TB] FAIL dl8_release: got %0d cycles expected %0d", cyc, SETTLE_CYCLES + 1);
    end
    checks++;
    if (seen_addr.size() != exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL dl8_write_count: got %0d expected %0d", seen_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if ({seen_addr[i], seen_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          errors++;
          $display("[TB] FAIL dl8_write[%0d]: got %h/%h expected %h/%h", i,
                   seen_addr[i], seen_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    for (int i = 1; i < 9; i++) begin
      checks++;
      if (mem_img[exp_addr[i]] !== exp_data[i]) begin
        errors++;
        $display("[TB] FAIL dl8_ram[%h]: got %h expected %h", exp_addr[i], mem_img[exp_addr[i]], exp_data[i]);
      end
    end
    checks++;
    if (dl_count !== (STATS ? 16'd8 : 16'd0)) begin
      errors++;
      $display("[TB] FAIL dl8_count: got %0d expected %0d", dl_count, STATS ? 8 : 0);
    end
  endtask

  task automatic test_latency();
    logic [AW-1:0] a;
    logic [7:0] d;
    int cyc;
    start_download(1'b1);
    a = 16'($urandom); d = 8'($urandom);
    dl_wr = 1'b1; dl_addr = {9'b0, a}; dl_data = d;
    tick(1);
    dl_wr = 1'b0;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_n1: got ram_we=%b expected 0", ram_we);
    end
    tick(1);
    checks++;
    if ({ram_we, ram_addr, ram_din} !== {1'b1, a, d}) begin
      errors++;
      $display("[TB] FAIL latency_n2: got we=%b %h/%h expected 1 %h/%h", ram_we, ram_addr, ram_din, a, d);
    end
    tick(2);
    dl_active = 1'b0;
    wait_release(cyc);
  endtask

  task automatic test_overflow();
    int cyc;
    clear_logs();
    dl_active = 1'b1; clk_ena = 1'b0;
    tick(2);
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1'b1; dl_addr = {9'b0, 16'($urandom)}; dl_data = 8'($urandom);
      if (i < FIFO_DEPTH) begin
        exp_addr.push_back(dl_addr[AW-1:0]); exp_data.push_back(dl_data);
      end
      tick(1);
    end
    dl_wr = 1'b0;
    tick(10);
    checks++;
    if (dl_overflow !== 1'b1 || seen_addr.size() != 0) begin
      errors++;
      $display("[TB] FAIL ovf_hold: got ovf=%b writes=%0d expected 1 0", dl_overflow, seen_addr.size());
    end
    clk_ena = 1'b1;
    tick(8);
    dl_active = 1'b0;
    wait_release(cyc);
    checks++;
    if (seen_addr.size() != exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL ovf_write_count: got %0d expected %0d", seen_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if ({seen_addr[i], seen_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          errors++;
          $display("[TB] FAIL ovf_write[%0d]: got %h/%h expected %h/%h", i,
                   seen_addr[i], seen_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (dl_overflow !== 1'b1 || dl_count !== (STATS ? 16'd4 : 16'd0)) begin
      errors++;
      $display("[TB] FAIL ovf_sticky: got ovf=%b cnt=%0d expected 1 %0d", dl_overflow, dl_count, STATS ? 4 : 0);
    end
    dl_active = 1'b1;
    tick(1);
    checks++;
    if (dl_overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got %b expected 0", dl_overflow);
    end
    tick(2);
    dl_active = 1'b0;
    wait_release(cyc);
  endtask

  task automatic test_range();
    int cyc;
    clear_logs();
    start_download(1'b1);
    dl_wr = 1'b1; dl_addr = 25'h010000; dl_data = 8'hA5;
    tick(1);
    dl_wr = 1'b0;
    checks++;
    if (dl_range_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL range_flag: got %b expected 1", dl_range_err);
    end
    tick(4);
    checks++;
    if (seen_addr.size() != 0) begin
      errors++;
      $display("[TB] FAIL range_no_write: got %0d writes expected 0", seen_addr.size());
    end
    dl_active = 1'b0;
    wait_release(cyc);
  endtask

  task automatic test_resettle();
    bit released = 0;
    int cyc;
    clear_logs();
    start_download(1'b1);
    checks++;
    if (dl_range_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL range_clear: got %b expected 0", dl_range_err);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        dl_wr = 1'b1; dl_addr = {9'b0, 16'($urandom)}; dl_data = 8'($urandom);
        exp_addr.push_back(dl_addr[AW-1:0]); exp_data.push_back(dl_data);
        tick(1);
      end
      dl_wr = 1'b0;
      tick(4);
      dl_active = 1'b0;
      if (r == 0) begin
        tick(1);
        dl_active = 1'b1;
        tick(2);
        if (cpu_wait_n !== 1'b0 || dl_busy !== 1'b1) released = 1;
      end
    end
    wait_release(cyc);
    checks++;
    if (released || cyc != SETTLE_CYCLES + 1) begin
      errors++;
      $display("[TB] FAIL resettle_wait: got early=%b release=%0d expected 0 %0d", released, cyc, SETTLE_CYCLES + 1);
    end
    checks++;
    if (seen_addr.size() != exp_addr.size()) begin
      errors++;
      $display("[TB] FAIL resettle_count: got %0d expected %0d", seen_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if ({seen_addr[i], seen_data[i]} !== {exp_addr[i], exp_data[i]}) begin
          errors++;
          $display("[TB] FAIL resettle_write[%0d]: got %h/%h expected %h/%h", i,
                   seen_addr[i], seen_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    checks++;
    if (dl_count !== (STATS ? 16'd3 : 16'd0)) begin
      errors++;
      $display("[TB] FAIL resettle_stats: got %0d expected %0d", dl_count, STATS ? 3 : 0);
    end
  endtask

  task automatic test_random(input int rounds);
    int cyc;
    bit any_bad;
    for (int r = 0; r < rounds; r++) begin
      clear_logs();
      any_bad = 0;
      start_download(1'b1);
      for (int i = 0; i < 30; i++) begin
        clk_ena = 1'($urandom);
        dl_wr   = ($urandom_range(0, 9) < 6);
        dl_data = 8'($urandom);
        if ($urandom_range(0, 7) == 0) dl_addr = 25'($urandom) | 25'h10000;
        else                           dl_addr = {9'b0, 16'($urandom)};
        if (dl_wr) begin
          if (dl_addr[24:AW] != 0) any_bad = 1;
          else begin
            exp_addr.push_back(dl_addr[AW-1:0]); exp_data.push_back(dl_data);
          end
        end
        tick(1);
      end
      dl_wr = 1'b0;
      tick(4);
      dl_active = 1'b0;
      wait_release(cyc);
      checks++;
      if (cyc != SETTLE_CYCLES + 1 || dl_range_err !== any_bad) begin
        errors++;
        $display("[TB] FAIL rand%0d_status: got release=%0d rng=%b expected %0d %b",
                 r, cyc, dl_range_err, SETTLE_CYCLES + 1, any_bad);
      end
      checks++;
      if (seen_addr.size() != exp_addr.size()) begin
        errors++;
        $display("[TB] FAIL rand%0d_count: got %0d expected %0d", r, seen_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          checks++;
          if ({seen_addr[i], seen_data[i]} !== {exp_addr[i], exp_data[i]}) begin
            errors++;
            $display("[TB] FAIL rand%0d_write[%0d]: got %h/%h expected %h/%h", r, i,
                     seen_addr[i], seen_data[i], exp_addr[i], exp_data[i]);
          end
        end
      end
      checks++;
      if (dl_count !== (STATS ? 16'(exp_addr.size()) : 16'd0)) begin
        errors++;
        $display("[TB] FAIL rand%0d_stats: got %0d expected %0d", r, dl_count, STATS ? exp_addr.size() : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    dl_active = 1'b1; clk_ena = 1'b0;
    tick(2);
    for (int i = 0; i < 3; i++) begin
      dl_wr = 1'b1; dl_addr = {9'b0, 16'($urandom)}; dl_data = 8'($urandom);
      tick(1);
    end
    dl_wr = 1'b0;
    checks++;
    if (cpu_wait_n !== 1'b0 || dl_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: got wait_n=%b busy=%b expected 0 1", cpu_wait_n, dl_busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cpu_wait_n, ram_we, dl_busy} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL async_reset: got wait_n=%b we=%b busy=%b expected 1 0 0", cpu_wait_n, ram_we, dl_busy);
    end
    tick(1);
    reset = 1'b0; dl_active = 1'b0; clk_ena = 1'b1;
    tick(12);
    checks++;
    if (seen_addr.size() != 0 || cpu_wait_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL post_reset: got writes=%0d wait_n=%b expected 0 1", seen_addr.size(), cpu_wait_n);
    end
  endtask

  initial begin
    $display("[TB] ram_access_arbiter bench start (stats=%0d)", STATS);
    test_reset();
    test_cpu_only();
    test_download8();
    test_latency();
    test_overflow();
    test_range();
    test_resettle();
    test_random(3);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
